sevenseg_capture: RTL
=====================

Name: sevenseg_capture

Overview:
- Receive side of the seven-segment link: samples a 7-bit segment bus and decodes it back to a 4-bit hex value.
- Filters glitches with a stability counter and reports each new stable pattern once through a valid/ready output.
- Used to read back and verify display drive, or to accept segment data from an external source.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is reported; legal range 1..(2^CNT_W)-1.
- CNT_W, 8, width of the stability counter.

Ports:
- clk  in  1  Single clock; all logic on the rising edge.
- reset_n  in  1  Synchronous reset, active-low.
- segments  in  7  Segment bus being read.
- out_ready  in  1  Consumer accepts the event on a cycle where out_valid=1.
- clr_overflow  in  1  Clears the overflow flag.
- out_valid  out  1  Event pending.
- out_value  out  4  Decoded hex digit.
- out_blank  out  1  Pattern was all-off (7'h00).
- out_err  out  1  Pattern is not a legal code.
- overflow  out  1  Sticky flag: an event was dropped.

Behaviour:
- Decode table (segments -> value):
  - 7d->0, 60->1, 3e->2, 7a->3, 63->4, 5b->5, 5f->6, 70->7
  - 7f->8, 7b->9, 77->A, 4f->B, 1d->C, 6e->D, 1f->E, 17->F
  - 00 -> blank: out_blank=1, out_value=0.
  - Any other pattern -> out_err=1, out_value=0, out_blank=0.
- Reset (reset_n=0 at an edge) clears:
  - all outputs to 0;
  - seg_q, cand and cnt to 0;
  - the have_reported and last_reported registers.
  - A pending event is discarded when reset is applied mid-operation.
- Input stage: seg_q <= segments every edge, giving one register of latency.
- Stability tracking:
  - If seg_q != cand: cand <= seg_q, cnt <= 1.
  - Else: cnt <= cnt+1, saturating at STABLE_CYCLES.
- Event condition: cnt_next == STABLE_CYCLES, and cnt != STABLE_CYCLES, and (have_reported==0 or cand_next != last_reported).
- On an event, last_reported <= cand_next and have_reported <= 1. This update happens whether the event is emitted, dropped or suppressed.
- Latency: out_valid rises on the edge STABLE_CYCLES edges after the edge that first loaded the new pattern into seg_q.
- Output register and handshake:
  - Payload (out_value, out_blank, out_err) is held stable while out_valid=1.
  - out_valid=1 and out_ready=1 at an edge with no event: out_valid <= 0.
  - Event when out_valid=0, or when out_valid=1 and out_ready=1 at the same edge: load the new payload, out_valid <= 1, no overflow.
  - Event when out_valid=1 and out_ready=0: the event is dropped, overflow <= 1, and the held payload is unchanged.
- Overflow flag: clr_overflow=1 clears it. If clr_overflow and a new drop occur at the same edge, set wins.
- A pattern that reappears after a different pattern has been reported is reported again. A pattern held indefinitely is reported only once.

Optional Feature:
- Macro SEVENSEG_CAPTURE_BLANK_REPORT_EN.
- Defined: a stable 7'h00 produces an event with out_blank=1.
- Undefined: blank events are suppressed. They never assert out_valid and never cause overflow, but they still update last_reported. Blank->3->blank->3 therefore reports 3 twice. The out_blank output is then tied to 0.

Test Plan:
- Reset then STABLE_CYCLES=4, segments=7'h7a held from edge 0, out_ready=1 -> out_valid=1 for exactly one cycle after edge 4, out_value=3, out_err=0; no further events while the pattern is held.
- segments toggles 7'h60/7'h3e every 2 cycles for 20 cycles, then holds 7'h17 -> no events during toggling; a single event with value F.
- segments=7'h55 held 4 cycles -> event with out_err=1, out_value=0.
- out_ready=0; present 7'h63 then 7'h5b, each stable 6 cycles -> payload stays value 4, overflow=1. Then out_ready=1 for one edge -> out_valid=0. Then clr_overflow and a drop on the same edge -> overflow stays 1.
- reset_n=0 while out_valid=1 -> all outputs 0 after the edge. Re-present the same pattern -> it is reported again (have_reported cleared).
- With and without the macro: 7'h00 held 4 cycles -> event with out_blank=1 when defined, no out_valid when undefined.

Source files
------------

// File: rtl/sevenseg_capture.sv
// Seven-segment receive path: glitch-filters the segment bus and reports each new stable
// pattern once as a decoded hex digit. Optional macro SEVENSEG_CAPTURE_BLANK_REPORT_EN enables blank events.
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] segments,
  input  logic       out_ready,
  input  logic       clr_overflow,
  output logic       out_valid,
  output logic [3:0] out_value,
  output logic       out_blank,
  output logic       out_err,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

`ifdef SEVENSEG_CAPTURE_BLANK_REPORT_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Returns {err, blank, value}.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b10_0000;
    case (seg)
      7'h7d: r = 6'h00;
      7'h60: r = 6'h01;
      7'h3e: r = 6'h02;
      7'h7a: r = 6'h03;
      7'h63: r = 6'h04;
      7'h5b: r = 6'h05;
      7'h5f: r = 6'h06;
      7'h70: r = 6'h07;
      7'h7f: r = 6'h08;
      7'h7b: r = 6'h09;
      7'h77: r = 6'h0a;
      7'h4f: r = 6'h0b;
      7'h1d: r = 6'h0c;
      7'h6e: r = 6'h0d;
      7'h1f: r = 6'h0e;
      7'h17: r = 6'h0f;
      7'h00: r = 6'b01_0000;
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [6:0]       seg_q;
  logic [6:0]       cand;
  logic [6:0]       cand_next;
  logic [6:0]       last_reported;
  logic             have_reported;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             evt;
  logic             emit;
  logic             drop;
  logic             load;
  logic [3:0]       dec_value;
  logic             dec_blank;
  logic             dec_err;
  logic             blank_q;

  // Output handshake: an event is transferred on any edge where out_valid=1 and out_ready=1;
  // the payload is held stable while out_valid=1, and an event arriving into a full,
  // unaccepted slot is dropped and recorded in overflow.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (seg_q != cand) begin
      cand_next = seg_q;
      cnt_next  = CNT_W'(1);
    end else if (cnt < STABLE) begin
      cnt_next = cnt + 1'b1;
    end
    evt = (cnt_next == STABLE) && (cnt != STABLE) &&
          (!have_reported || (cand_next != last_reported));
    {dec_err, dec_blank, dec_value} = decode(cand_next);
    // Suppressed blanks still count as reported, so the next digit is seen as new.
    emit = evt && (BLANK_EN || !dec_blank);
    drop = emit && out_valid && !out_ready;
    load = emit && !drop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q         <= '0;
      cand          <= '0;
      cnt           <= '0;
      last_reported <= '0;
      have_reported <= 1'b0;
      out_valid     <= 1'b0;
      out_value     <= '0;
      blank_q       <= 1'b0;
      out_err       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      seg_q <= segments;
      cand  <= cand_next;
      cnt   <= cnt_next;
      if (evt) begin
        last_reported <= cand_next;
        have_reported <= 1'b1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_value <= dec_value;
        blank_q   <= dec_blank;
        out_err   <= dec_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign out_blank = BLANK_EN && blank_q;

endmodule
